ifu_inst_queue: RTL and testbench
=================================

// Module: ifu_inst_queue
// PURPOSE
//  Instruction queue between the fetch unit and the decode stage. Fetched words arrive from
//  the fetch unit's AXI read path, one per valid cycle, and are buffered in order. They are
//  presented to decode with a valid/stall handshake. Back-pressure (almost_full_o) feeds the
//  fetch unit's PC stall so that in-flight AXI reads always have a slot.
//  Jump/flush empties the queue in one cycle.
// PARAMETERS
//  DEPTH      4  number of entries; power of two, >=2
//  AF_SLOTS   2  almost_full_o asserts when free slots <= AF_SLOTS (covers outstanding reads)
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  asynchronous active-low reset
//  inst_i         in   `INST_DATA_WIDTH   fetched instruction word
//  inst_addr_i    in   `INST_ADDR_WIDTH   address of inst_i
//  inst_valid_i   in   1                  push request; inst_i/inst_addr_i/resp_err_i valid
//  resp_err_i     in   1                  AXI read response error for this word
//  flush_i        in   1                  jump/flush: discard all entries and this cycle's push
//  stall_id_i     in   1                  decode cannot accept; head is held
//  inst_o         out  `INST_DATA_WIDTH   head instruction; INST_NOP when inst_valid_o=0
//  inst_addr_o    out  `INST_ADDR_WIDTH   head address; 0 when inst_valid_o=0
//  inst_err_o     out  1                  head carries a fetch error; 0 when inst_valid_o=0
//  inst_valid_o   out  1                  queue non-empty
//  almost_full_o  out  1                  free slots <= AF_SLOTS
//  full_o         out  1                  count == DEPTH
//  overflow_o     out  1                  one-cycle pulse: a push was dropped (protocol error)
// BEHAVIOUR
//  - Storage: DEPTH entries {inst, addr, err}. wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap
//    naturally. count is $clog2(DEPTH)+1 bits.
//  - Reset (async, rst_n=0): pointers and count = 0, overflow_o = 0. Outputs then read
//    inst_valid_o=0, inst_o=INST_NOP, inst_addr_o=0, inst_err_o=0, full_o=0,
//    almost_full_o = (DEPTH<=AF_SLOTS). Entry contents need no reset.
//  - pop  = inst_valid_o & ~stall_id_i & ~flush_i.
//  - push = inst_valid_i & ~flush_i & (~full_o | pop). Full with a simultaneous pop is a legal
//    push: count stays at DEPTH.
//  - Latency: a word pushed in cycle N appears at the head in cycle N+1 if the queue was empty.
//    There is no same-cycle bypass. Outputs are read combinationally from mem[rd_ptr],
//    gated by inst_valid_o.
//  - Ordering: strict FIFO. err travels with its word. An error entry is still popped normally;
//    decode/trap logic handles it.
//  - stall_id_i=1: head, rd_ptr and all head outputs are held stable. Pushes continue until full.
//  - flush_i=1 (highest priority): next cycle count=0, rd_ptr=wr_ptr, inst_valid_o=0.
//    The incoming word is dropped silently (no overflow_o), and nothing pops that cycle.
//  - Overflow: inst_valid_i & ~flush_i & full_o & ~pop -> word dropped, overflow_o=1 for one
//    cycle, state unchanged.
//  - full_o and almost_full_o are combinational from the registered count. They depend on no
//    input in the same cycle, so there is no path from decode stall to fetch.
//  - Reset mid-operation: all entries are lost immediately. The first post-reset push behaves
//    as on an empty queue.
// STRUCTURE
//  - Shared package ifu_pkg: typedef struct packed {logic err; addr; inst;} ifq_entry_t, and
//    localparam INST_NOP = 32'h0000_0013.
//  - One module, no sub-module. Storage is a flop array of ifq_entry_t, plus pointer/count
//    registers.
// TESTING
//  1 Reset, then push 0x00500093@0x80000000 -> next cycle inst_valid_o=1, inst_o=0x00500093,
//    inst_addr_o=0x80000000.
//  2 Push 4 words with stall_id_i=1 -> full_o=1, almost_full_o=1 from count=2. A 5th push gives
//    overflow_o pulse and the head is unchanged.
//  3 Full queue, push + pop same cycle -> count stays 4; pop order matches push order exactly.
//  4 3 entries queued, flush_i=1 with inst_valid_i=1 -> next cycle inst_valid_o=0,
//    inst_o=INST_NOP, overflow_o=0.
//  5 Push a word with resp_err_i=1 between two good words -> inst_err_o=1 only on the
//    2nd popped word.
//  6 rst_n low for 1 cycle while 2 entries queued -> outputs at reset values asynchronously;
//    the next push appears after 1 cycle.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types and constants for the IFU instruction queue.
package ifu_pkg;

    localparam int unsigned INST_DATA_WIDTH = 32;
    localparam int unsigned INST_ADDR_WIDTH = 32;

    localparam logic [INST_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic                       err;
        logic [INST_ADDR_WIDTH-1:0] addr;
        logic [INST_DATA_WIDTH-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/ifu_inst_queue.sv
// Fetch-to-decode instruction FIFO with flush, back-pressure and overflow reporting.
module ifu_inst_queue
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AF_SLOTS = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INST_DATA_WIDTH-1:0] inst_i,
    input  logic [INST_ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                       inst_valid_i,
    input  logic                       resp_err_i,
    input  logic                       flush_i,
    input  logic                       stall_id_i,
    output logic [INST_DATA_WIDTH-1:0] inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic                       inst_err_o,
    output logic                       inst_valid_o,
    output logic                       almost_full_o,
    output logic                       full_o,
    output logic                       overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    ifq_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push, pop;
    logic [31:0]      free_slots;
    ifq_entry_t       head;

    // Status flags come only from registered count: no decode-stall path into fetch.
    assign free_slots    = 32'(DEPTH) - 32'(count_q);
    assign full_o        = (32'(count_q) == 32'(DEPTH));
    assign almost_full_o = (free_slots <= 32'(AF_SLOTS));
    assign inst_valid_o  = (count_q != '0);
    assign overflow_o    = overflow_q;

    assign head        = mem_q[rd_ptr_q];
    assign inst_o      = inst_valid_o ? head.inst : INST_NOP;
    assign inst_addr_o = inst_valid_o ? head.addr : '0;
    assign inst_err_o  = inst_valid_o & head.err;

    assign pop  = inst_valid_o & ~stall_id_i & ~flush_i;
    assign push = inst_valid_i & ~flush_i & (~full_o | pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = inst_valid_i & ~flush_i & full_o & ~pop;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{err: resp_err_i, addr: inst_addr_i, inst: inst_i};
    end

endmodule

// File: tb/tb_ifu_inst_queue.sv
// Directed scoreboard bench for ifu_inst_queue.
module tb_ifu_inst_queue;
    import ifu_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AF_SLOTS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_i = '0, inst_addr_i = '0;
    logic        inst_valid_i = 1'b0, resp_err_i = 1'b0, flush_i = 1'b0, stall_id_i = 1'b0;
    logic [31:0] inst_o, inst_addr_o;
    logic        inst_err_o, inst_valid_o, almost_full_o, full_o, overflow_o;

    int checks = 0;
    int errors = 0;
    ifq_entry_t sb[$];

    always #5 clk = ~clk;

    ifu_inst_queue #(.DEPTH(DEPTH), .AF_SLOTS(AF_SLOTS)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
        .resp_err_i(resp_err_i), .flush_i(flush_i), .stall_id_i(stall_id_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_err_o(inst_err_o),
        .inst_valid_o(inst_valid_o), .almost_full_o(almost_full_o),
        .full_o(full_o), .overflow_o(overflow_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        chk({tag, "_inst"}, inst_o, INST_NOP);
        chk({tag, "_addr"}, inst_addr_o, 32'd0);
        chk({tag, "_err"}, 32'(inst_err_o), 32'd0);
        chk({tag, "_full"}, 32'(full_o), 32'd0);
        chk({tag, "_af"}, 32'(almost_full_o), 32'((DEPTH <= AF_SLOTS) ? 1 : 0));
        chk({tag, "_ovf"}, 32'(overflow_o), 32'd0);
    endtask

    // Post-edge state check against the scoreboard occupancy and head.
    task automatic chk_state(input string tag, input logic exp_ovf);
        int n;
        n = sb.size();
        chk({tag, "_valid"}, 32'(inst_valid_o), 32'(n > 0));
        chk({tag, "_full"}, 32'(full_o), 32'(n == DEPTH));
        chk({tag, "_af"}, 32'(almost_full_o), 32'((DEPTH - n) <= AF_SLOTS));
        chk({tag, "_ovf"}, 32'(overflow_o), 32'(exp_ovf));
        if (n > 0) begin
            chk({tag, "_head_inst"}, inst_o, sb[0].inst);
            chk({tag, "_head_addr"}, inst_addr_o, sb[0].addr);
            chk({tag, "_head_err"}, 32'(inst_err_o), 32'(sb[0].err));
        end else begin
            chk({tag, "_nop"}, inst_o, INST_NOP);
            chk({tag, "_zaddr"}, inst_addr_o, 32'd0);
            chk({tag, "_zerr"}, 32'(inst_err_o), 32'd0);
        end
    endtask

    task automatic cycle(input string tag, input logic v, input logic [31:0] d, input logic [31:0] a,
                         input logic e, input logic fl, input logic st);
        logic       full_m, exp_pop, exp_push, exp_ovf;
        ifq_entry_t h;
        inst_valid_i = v; inst_i = d; inst_addr_i = a; resp_err_i = e;
        flush_i = fl; stall_id_i = st;
        #1;
        full_m   = (sb.size() == DEPTH);
        exp_pop  = (sb.size() > 0) && !st && !fl;
        exp_push = v && !fl && (!full_m || exp_pop);
        exp_ovf  = v && !fl && full_m && !exp_pop;
        if (exp_pop) begin
            h = sb.pop_front();
            chk({tag, "_pop_inst"}, inst_o, h.inst);
            chk({tag, "_pop_addr"}, inst_addr_o, h.addr);
            chk({tag, "_pop_err"}, 32'(inst_err_o), 32'(h.err));
        end
        if (fl) sb.delete();
        if (exp_push) sb.push_back('{err: e, addr: a, inst: d});
        @(posedge clk);
        #1;
        chk_state(tag, exp_ovf);
    endtask

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // 1: single push, visible next cycle, then popped
        cycle("t1_push", 1, 32'h0050_0093, 32'h8000_0000, 0, 0, 0);
        chk("t1_inst", inst_o, 32'h0050_0093);
        chk("t1_addr", inst_addr_o, 32'h8000_0000);
        cycle("t1_pop", 0, '0, '0, 0, 0, 0);

        // 2: fill under stall, then overflow with head held
        for (int i = 0; i < 4; i++)
            cycle("t2_fill", 1, 32'h1000_0000 + 32'(i), 32'h8000_0100 + 32'(4 * i), 0, 0, 1);
        chk("t2_full", 32'(full_o), 32'd1);
        cycle("t2_ovf", 1, 32'hDEAD_BEEF, 32'h8000_0200, 0, 0, 1);
        chk("t2_ovf_pulse", 32'(overflow_o), 32'd1);
        chk("t2_head_held", inst_o, 32'h1000_0000);
        cycle("t2_ovf_clr", 0, '0, '0, 0, 0, 1);

        // 3: full push+pop keeps count at DEPTH, then drain in order
        for (int i = 0; i < 3; i++)
            cycle("t3_pp", 1, 32'h2000_0000 + 32'(i), 32'h8000_0300 + 32'(4 * i), 0, 0, 0);
        chk("t3_still_full", 32'(full_o), 32'd1);
        for (int i = 0; i < 4; i++) cycle("t3_drain", 0, '0, '0, 0, 0, 0);

        // 4: flush with a concurrent push drops everything silently
        for (int i = 0; i < 3; i++)
            cycle("t4_fill", 1, 32'h3000_0000 + 32'(i), 32'h8000_0400 + 32'(4 * i), 0, 0, 1);
        cycle("t4_flush", 1, 32'h3333_3333, 32'h8000_0500, 0, 1, 0);
        chk("t4_valid", 32'(inst_valid_o), 32'd0);
        chk("t4_nop", inst_o, INST_NOP);
        chk("t4_ovf", 32'(overflow_o), 32'd0);
        cycle("t4_after", 1, 32'h3444_4444, 32'h8000_0600, 0, 0, 0);
        cycle("t4_pop", 0, '0, '0, 0, 0, 0);

        // 5: error flag travels with the middle word only
        cycle("t5_a", 1, 32'h4000_0001, 32'h8000_0700, 0, 0, 1);
        cycle("t5_b", 1, 32'h4000_0002, 32'h8000_0704, 1, 0, 1);
        cycle("t5_c", 1, 32'h4000_0003, 32'h8000_0708, 0, 0, 1);
        cycle("t5_pop1", 0, '0, '0, 0, 0, 0);
        chk("t5_err2", 32'(inst_err_o), 32'd1);
        cycle("t5_pop2", 0, '0, '0, 0, 0, 0);
        chk("t5_err3", 32'(inst_err_o), 32'd0);
        cycle("t5_pop3", 0, '0, '0, 0, 0, 0);

        // 6: asynchronous reset with entries queued
        cycle("t6_a", 1, 32'h5000_0001, 32'h8000_0800, 0, 0, 1);
        cycle("t6_b", 1, 32'h5000_0002, 32'h8000_0804, 1, 0, 1);
        inst_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t6_async");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("t6_push", 1, 32'h5555_0001, 32'h8000_0900, 0, 0, 0);
        chk("t6_inst", inst_o, 32'h5555_0001);
        cycle("t6_pop", 0, '0, '0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
